// File: rtl/spi_link_pkg.sv
// Shared definitions for the 3-wire serial display link (transmitter and receiver).
package spi_link_pkg;

    localparam int WORD_W_DEF = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width needed to index n items; never returns 0 so widths stay legal.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through FIFO for received words; DEPTH must be a power of 2.
module spi_rx_fifo
    import spi_link_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW:0]                 wr_ptr_q, rd_ptr_q;
    logic                        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop on the same cycle frees the slot, so a push while full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_display_rx.sv
// Oversampling receiver for the CSX/SCL/SDA display link; LSB-first words out on valid/ready.
// Define SPI_RX_FIFO_EN to replace the single holding register with an spi_rx_fifo.
module spi_display_rx
    import spi_link_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int SYNC_N = 2,
    parameter int FIFO_D = 4
) (
    input  logic              CLK,
    input  logic              RESX,
    input  logic              CSX,
    input  logic              SCL,
    input  logic              SDA,
    output logic [WORD_W-1:0] DATA,
    output logic              VALID,
    input  logic              READY,
    output logic              BUSY,
    output logic              FRAME_ERR,
    output logic              OVERRUN
);

    localparam int BC_W = clog2(WORD_W);

    if (SYNC_N < 2 || FIFO_D < 2 || (FIFO_D & (FIFO_D - 1)) != 0) begin : g_param_chk
        $error("spi_display_rx: SYNC_N must be >= 2 and FIFO_D a power of 2 >= 2");
    end

    logic [SYNC_N-1:0] csx_sync_q, scl_sync_q, sda_sync_q;
    logic              scl_d_q;
    logic              csx_s, scl_s, sda_s, rise;

    state_e            state_q, state_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              push_q, push_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    assign csx_s = csx_sync_q[SYNC_N-1];
    assign scl_s = scl_sync_q[SYNC_N-1];
    assign sda_s = sda_sync_q[SYNC_N-1];
    assign rise  = scl_s & ~scl_d_q;

    // Equal-depth chains keep SDA aligned with the SCL edge it belongs to.
    always_ff @(posedge CLK or negedge RESX) begin
        if (!RESX) begin
            csx_sync_q <= '1;
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            scl_d_q    <= 1'b0;
        end else begin
            csx_sync_q <= {csx_sync_q[SYNC_N-2:0], CSX};
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], SDA};
            scl_d_q    <= scl_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        push_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!csx_s) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                // CSX release wins over a coincident rise; a partial word is discarded.
                if (csx_s) begin
                    state_d  = IDLE;
                    ferr_d   = (bitcnt_q != '0);
                    bitcnt_d = '0;
                end else if (rise) begin
                    shreg_d[bitcnt_q] = sda_s;
                    if (bitcnt_q == BC_W'(WORD_W - 1)) begin
                        bitcnt_d = '0;
                        push_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESX) begin
        if (!RESX) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            push_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            push_q   <= push_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign BUSY      = (state_q == SHIFT);
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

    // push_q marks the cycle after completion; shreg_q then holds the whole word.
`ifdef SPI_RX_FIFO_EN
    logic full, empty, pop;

    assign pop   = !empty && READY;
    assign VALID = !empty;
    assign ovr_d = ovr_q | (push_q && full && !pop);

    spi_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESX),
        .push_i  (push_q),
        .din_i   (shreg_q),
        .pop_i   (pop),
        .dout_o  (DATA),
        .full_o  (full),
        .empty_o (empty)
    );
`else
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (push_q) begin
            if (valid_q && !READY) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESX) begin
        if (!RESX) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
`endif

endmodule

// File: tb/tb_spi_display_rx.sv
// Scoreboard bench for spi_display_rx: words queued as sent, checked when handed over.
`timescale 1ns/1ps
module tb_spi_display_rx;

    localparam int W      = 18;
    localparam int FIFO_D = 4;
`ifdef SPI_RX_FIFO_EN
    localparam int NHELD = FIFO_D;
`else
    localparam int NHELD = 1;
`endif

    logic         CLK = 1'b0;
    logic         RESX = 1'b0;
    logic         CSX = 1'b1;
    logic         SCL = 1'b0;
    logic         SDA = 1'b0;
    logic         READY = 1'b1;
    logic [W-1:0] DATA;
    logic         VALID, BUSY, FRAME_ERR, OVERRUN;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    logic [W-1:0] exp_q[$];

    spi_display_rx #(.WORD_W(W), .SYNC_N(2), .FIFO_D(FIFO_D)) dut (
        .CLK(CLK), .RESX(RESX), .CSX(CSX), .SCL(SCL), .SDA(SDA),
        .DATA(DATA), .VALID(VALID), .READY(READY), .BUSY(BUSY),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    always #7.8125 CLK = ~CLK;

    always @(negedge CLK) begin : monitor
        logic [W-1:0] exp_w;
        if (RESX && FRAME_ERR) ferr_cnt++;
        if (RESX && VALID && READY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: DATA=%h but no word expected", DATA);
            end else begin
                exp_w = exp_q.pop_front();
                if (DATA !== exp_w) begin
                    errors++;
                    $display("FAIL pop_data: DATA=%h expected %h", DATA, exp_w);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SDA = b; SCL = 1'b0; tick(4);
        SCL = 1'b1; tick(4);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send_bit(w[i]);
    endtask

    task automatic frame_start();
        CSX = 1'b0; tick(2);
    endtask

    task automatic frame_end();
        SCL = 1'b0; tick(4);
        CSX = 1'b1; tick(8);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(1); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RESX = 1'b0; tick(2);
        checks++;
        if ({DATA, VALID, BUSY, FRAME_ERR, OVERRUN} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b expected all 0", DATA, VALID, BUSY, FRAME_ERR, OVERRUN);
        end
        RESX = 1'b1; tick(4);
    endtask

    task automatic test_single_word();
        logic [W-1:0] w;
        w = 18'b100000111000110001;
        ferr_cnt = 0;
        frame_start();
        for (int i = 0; i < W - 1; i++) send_bit(w[i]);
        SDA = w[W-1]; SCL = 1'b0; tick(4);
        exp_q.push_back(18'h20E31);
        SCL = 1'b1; tick(3);
        checks++;
        if (VALID !== 1'b0) begin errors++; $display("FAIL latency_early: VALID=%b expected 0", VALID); end
        tick(1);
        checks++;
        if (VALID !== 1'b1) begin errors++; $display("FAIL latency_edge4: VALID=%b expected 1", VALID); end
        tick(3);
        frame_end();
        drain("single");
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr: pulses=%0d expected 0", ferr_cnt); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy: BUSY=%b expected 0", BUSY); end
    endtask

    task automatic test_back_to_back();
        frame_start();
        exp_q.push_back(18'h3FFFF); send_word(18'h3FFFF);
        exp_q.push_back(18'h00001); send_word(18'h00001);
        frame_end();
        drain("b2b");
        checks++;
        if (OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_overrun: OVERRUN=%b expected 0", OVERRUN); end
    endtask

    task automatic test_frame_err();
        int pulses;
        pulses = 0;
        frame_start();
        for (int i = 0; i < 7; i++) send_bit(i[0]);
        SCL = 1'b0; tick(4);
        CSX = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(1); if (FRAME_ERR === 1'b1) pulses++; end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ferr_width: cycles=%0d expected 1", pulses); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL ferr_busy: BUSY=%b expected 0", BUSY); end
        frame_start();
        exp_q.push_back(18'h15555); send_word(18'h15555);
        frame_end();
        drain("ferr_next");
    endtask

    task automatic test_overrun();
        logic [W-1:0] words[5];
        words = '{18'h0AAAA, 18'h12345, 18'h2FEDC, 18'h00F0F, 18'h3C3C3};
        READY = 1'b0;
        frame_start();
        for (int i = 0; i <= NHELD; i++) begin
            if (i < NHELD) exp_q.push_back(words[i]);
            send_word(words[i]);
        end
        frame_end();
        checks++;
        if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_flag: OVERRUN=%b expected 1", OVERRUN); end
        checks++;
        if (VALID !== 1'b1 || DATA !== words[0]) begin
            errors++;
            $display("FAIL ovr_held: VALID=%b DATA=%h expected 1/%h", VALID, DATA, words[0]);
        end
        READY = 1'b1;
        drain("ovr");
        tick(2);
        checks++;
        if (VALID !== 1'b0) begin errors++; $display("FAIL ovr_empty: VALID=%b expected 0", VALID); end
    endtask

    task automatic test_reset_midframe();
        ferr_cnt = 0;
        frame_start();
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        SCL = 1'b0; tick(2);
        RESX = 1'b0; #1;
        checks++;
        if ({DATA, VALID, BUSY, FRAME_ERR, OVERRUN} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h/%b%b%b%b expected all 0", DATA, VALID, BUSY, FRAME_ERR, OVERRUN);
        end
        tick(1);
        RESX = 1'b1; tick(4);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL midrst_reentry: BUSY=%b expected 1", BUSY); end
        exp_q.push_back(18'h2D2D2); send_word(18'h2D2D2);
        frame_end();
        drain("midrst");
        checks++;
        if (ferr_cnt != 0) begin errors++; $display("FAIL midrst_ferr: pulses=%0d expected 0", ferr_cnt); end
    endtask

    task automatic test_scl_idle();
        int busy_hi, vld_hi;
        busy_hi = 0; vld_hi = 0;
        CSX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            if (BUSY === 1'b1) busy_hi++;
            if (VALID === 1'b1) vld_hi++;
        end
        SCL = 1'b0; tick(6);
        checks++;
        if (busy_hi != 0 || vld_hi != 0) begin
            errors++;
            $display("FAIL idle_scl: busy=%0d valid=%0d samples expected 0/0", busy_hi, vld_hi);
        end
        frame_start();
        exp_q.push_back(18'h0C3A5); send_word(18'h0C3A5);
        frame_end();
        drain("idle_next");
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_single_word();
                test_back_to_back();
                test_frame_err();
                test_overrun();
                test_reset_midframe();
                test_scl_idle();
            end
            begin
                #2ms;
                errors++;
                $display("FAIL watchdog: time limit expired, expected completion");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
